dft_engine: RTL and testbench
=============================

DFT_ENGINE -- requirements
Module: dft_engine

Interface
REQ-001 SHALL have parameter N, default 16, meaning the transform length (power of two, 4..256).
REQ-002 SHALL have parameter W, default 16, meaning the signed sample and result width.
REQ-003 SHALL have parameter TW, default 16, meaning the signed Q1.(TW-1) twiddle width.
REQ-004 SHALL have port clk, input, 1 bit, the clock.
REQ-005 SHALL have port reset, input, 1 bit, the synchronous active-high reset.
REQ-006 SHALL have port in_valid, input, 1 bit, meaning an input sample is offered.
REQ-007 SHALL have port in_ready, output, 1 bit, meaning the engine accepts a sample this cycle.
REQ-008 SHALL have ports in_re and in_im, input, W bits each, meaning the signed complex sample.
REQ-009 SHALL have port inverse, input, 1 bit, meaning the frame uses conjugate twiddles.
REQ-010 SHALL have port out_valid, input-side ready out_ready, and data out_re and out_im (W bits each), out_idx ($clog2(N) bits), meaning the result bin handshake.
REQ-011 SHALL have port busy, output, 1 bit, high outside IDLE.

Function
REQ-012 SHALL use FSM states IDLE, LOAD, COMPUTE, EMIT.
REQ-013 In IDLE/LOAD, SHALL assert in_ready; a sample transfers when in_valid && in_ready and is stored at sample index 0..N-1 in order.
REQ-014 SHALL capture inverse on the transfer of sample 0 and hold it for the whole frame; IDLE->LOAD on that transfer.
REQ-015 On transfer of sample N-1, SHALL go to COMPUTE with in_ready low until the frame completes.
REQ-016 COMPUTE SHALL perform one complex MAC per cycle over j=0..N-1 for bin k, using twiddle index (k*j) mod N.
REQ-017 Forward MAC: re += xr*c + xi*s; im += xi*c - xr*s, where c=cos(2*pi*m/N), s=sin(2*pi*m/N); inverse SHALL negate s.
REQ-018 The accumulator SHALL be W+TW+$clog2(N) bits signed; no overflow is possible inside it.
REQ-019 The result SHALL be (acc + 2^(TW-2)) >>> (TW-1), reduced to W bits per REQ-027/028.
REQ-020 After N MACs, SHALL enter EMIT with out_valid high, out_idx=k, and data stable until out_valid && out_ready.
REQ-021 On transfer, SHALL clear the accumulator and return to COMPUTE for k+1, or to IDLE after k=N-1.
REQ-022 Per-bin latency SHALL be N compute cycles plus 1 cycle before out_valid under no backpressure.
REQ-023 out_ready low SHALL stall indefinitely with no loss or alteration of data.

Reset
REQ-024 On reset, SHALL force IDLE, clear the sample counter, bin counter, and accumulator, and clear in_ready for that cycle.
REQ-025 Reset SHALL drive out_valid=0, out_re=0, out_im=0, out_idx=0, busy=0; sample memory contents need not be cleared.
REQ-026 Reset asserted mid-LOAD/COMPUTE/EMIT SHALL abandon the frame; the next frame starts at sample index 0.

Configuration
REQ-027 With DFT_SAT_EN defined, the result SHALL saturate to [-2^(W-1), 2^(W-1)-1].
REQ-028 Without DFT_SAT_EN, the result SHALL be the low W bits of the rounded value (wrap).

Structure
REQ-029 Package dft_pkg SHALL hold the state enum, Q-format constants, and the twiddle-generation function.
REQ-030 Sub-module dft_twiddle_rom SHALL hold N entries of (cos, sin), with round(32767*...) at TW=16, and one-cycle registered read.
REQ-031 The twiddle pipeline stage SHALL be accounted for inside the REQ-022 latency.

Verification
REQ-032 Impulse, N=16, forward: x[0]=1000+0j, rest 0 -> all 16 bins re=1000, im=0, out_idx 0..15 in order.
REQ-033 DC input: all x=100+0j -> bin0 re=1600, im=0; bins 1..15 |re|,|im| <= 1.
REQ-034 Inverse round-trip: forward output of an impulse at x[3]=500 is fed back with inverse=1 -> bin 3 re=8000 (N*500), others |value| <= N.
REQ-035 Backpressure: out_ready low for 20 cycles during bin 5 -> out_re/out_im/out_idx are constant; no bin is skipped or duplicated.
REQ-036 Overflow: all x=32767 -> with DFT_SAT_EN bin0 re=32767; without it bin0 re equals the low 16 bits of the rounded value.
REQ-037 Reset during COMPUTE of bin 7 -> next cycle busy=0, out_valid=0; a new impulse frame reproduces the REQ-032 result.

Source files
------------

// File: rtl/dft_pkg.sv
// Shared types, Q-format helpers and twiddle generation for the dft_engine slice.
// Twiddles are round((2^(TW-1)-1) * cos/sin(2*pi*m/N)) and are evaluated at elaboration time only.
package dft_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        COMPUTE = 2'd2,
        EMIT    = 2'd3
    } state_t;

    localparam int  TW_DEFAULT = 16;
    localparam real TWO_PI     = 6.283185307179586476925;

    // Fraction bits of a Q1.(tw-1) twiddle.
    function automatic int q_frac_bits(input int tw);
        return tw - 1;
    endfunction

    // Largest positive twiddle magnitude; +1.0 itself is not representable.
    function automatic int q_one(input int tw);
        return (1 << (tw - 1)) - 1;
    endfunction

    // Half an output LSB, added before the arithmetic shift for round-half-up.
    function automatic int q_half_lsb(input int tw);
        return 1 << (tw - 2);
    endfunction

    // Round-to-nearest (ties away from zero) twiddle component for index m of an n-point table.
    function automatic int twiddle_q(input int m, input int n, input int tw, input bit want_sin);
        real ang;
        real val;
        ang = TWO_PI * $itor(m) / $itor(n);
        val = $itor(q_one(tw)) * (want_sin ? $sin(ang) : $cos(ang));
        if (val >= 0.0)
            return $rtoi(val + 0.5);
        else
            return -$rtoi(0.5 - val);
    endfunction

endpackage

// File: rtl/dft_twiddle_rom.sv
// N-entry (cos, sin) twiddle table with a registered read port.
// Contents are elaboration-time constants so the table maps to ROM or distributed logic.
module dft_twiddle_rom
    import dft_pkg::*;
#(
    parameter int N  = 16,
    parameter int TW = 16
) (
    input  logic                     clk,
    input  logic [$clog2(N)-1:0]     addr,
    output logic signed [TW-1:0]     cos_q,
    output logic signed [TW-1:0]     sin_q
);
    logic signed [TW-1:0] cos_tab [N];
    logic signed [TW-1:0] sin_tab [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_tab
        localparam logic signed [TW-1:0] COS_V = TW'(twiddle_q(gi, N, TW, 1'b0));
        localparam logic signed [TW-1:0] SIN_V = TW'(twiddle_q(gi, N, TW, 1'b1));
        assign cos_tab[gi] = COS_V;
        assign sin_tab[gi] = SIN_V;
    end

    always_ff @(posedge clk) begin
        cos_q <= cos_tab[addr];
        sin_q <= sin_tab[addr];
    end

endmodule

// File: rtl/dft_engine.sv
// Direct-form DFT: load N samples, then one complex MAC per cycle per bin, bins emitted in order.
// Build option DFT_SAT_EN: saturate each result to W bits; otherwise the low W bits are kept (wrap).
module dft_engine
    import dft_pkg::*;
#(
    parameter int N  = 16,
    parameter int W  = 16,
    parameter int TW = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [W-1:0]      in_re,
    input  logic signed [W-1:0]      in_im,
    input  logic                     inverse,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [W-1:0]      out_re,
    output logic signed [W-1:0]      out_im,
    output logic [$clog2(N)-1:0]     out_idx,
    output logic                     busy
);
    localparam int LW   = $clog2(N);
    localparam int PW   = W + TW;
    localparam int SW   = PW + 1;
    localparam int AW   = W + TW + LW;
    localparam int FRAC = q_frac_bits(TW);
    localparam logic signed [AW-1:0] ROUND_BIAS = AW'(q_half_lsb(TW));
    localparam logic [LW-1:0]        LAST       = LW'(N - 1);

    state_t               state_reg;
    logic [LW-1:0]        samp_cnt_reg;
    logic [LW-1:0]        bin_reg;
    logic [LW-1:0]        j_reg;
    logic [LW-1:0]        tw_idx_reg;
    logic                 issue_reg;
    logic                 mac_valid_reg;
    logic                 mac_last_reg;
    logic                 inv_reg;
    logic                 in_ready_reg;
    logic                 out_valid_reg;
    logic signed [W-1:0]  out_re_reg;
    logic signed [W-1:0]  out_im_reg;
    logic [LW-1:0]        out_idx_reg;
    logic signed [AW-1:0] acc_re_reg;
    logic signed [AW-1:0] acc_im_reg;

    logic signed [W-1:0]  mem_re [N];
    logic signed [W-1:0]  mem_im [N];
    logic signed [W-1:0]  x_re_reg;
    logic signed [W-1:0]  x_im_reg;
    logic signed [TW-1:0] cos_q;
    logic signed [TW-1:0] sin_q;
    logic                 load_fire;

    assign load_fire = in_valid && in_ready_reg && (state_reg == IDLE || state_reg == LOAD);

    // Sample store: written in arrival order, read one cycle ahead of the MAC alongside the twiddle.
    always_ff @(posedge clk) begin
        if (load_fire) begin
            mem_re[samp_cnt_reg] <= in_re;
            mem_im[samp_cnt_reg] <= in_im;
        end
        x_re_reg <= mem_re[j_reg];
        x_im_reg <= mem_im[j_reg];
    end

    dft_twiddle_rom #(
        .N  (N),
        .TW (TW)
    ) u_rom (
        .clk   (clk),
        .addr  (tw_idx_reg),
        .cos_q (cos_q),
        .sin_q (sin_q)
    );

    logic signed [PW-1:0] prod_rc;
    logic signed [PW-1:0] prod_is;
    logic signed [PW-1:0] prod_ic;
    logic signed [PW-1:0] prod_rs;
    logic signed [SW-1:0] term_re;
    logic signed [SW-1:0] term_im;
    logic signed [AW-1:0] acc_re_next;
    logic signed [AW-1:0] acc_im_next;

    // The inverse transform conjugates the twiddle, which only flips the sign of the sine terms.
    always_comb begin
        prod_rc = PW'(x_re_reg) * PW'(cos_q);
        prod_is = PW'(x_im_reg) * PW'(sin_q);
        prod_ic = PW'(x_im_reg) * PW'(cos_q);
        prod_rs = PW'(x_re_reg) * PW'(sin_q);
        if (inv_reg) begin
            term_re = SW'(prod_rc) - SW'(prod_is);
            term_im = SW'(prod_ic) + SW'(prod_rs);
        end else begin
            term_re = SW'(prod_rc) + SW'(prod_is);
            term_im = SW'(prod_ic) - SW'(prod_rs);
        end
        acc_re_next = acc_re_reg + AW'(term_re);
        acc_im_next = acc_im_reg + AW'(term_im);
    end

`ifdef DFT_SAT_EN
    localparam logic signed [AW-1:0] SAT_MAX = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};
`endif

    function automatic logic signed [W-1:0] round_reduce(input logic signed [AW-1:0] acc);
        logic signed [AW-1:0] rounded;
        rounded = (acc + ROUND_BIAS) >>> FRAC;
`ifdef DFT_SAT_EN
        if (rounded > SAT_MAX)
            rounded = SAT_MAX;
        else if (rounded < SAT_MIN)
            rounded = SAT_MIN;
`endif
        return rounded[W-1:0];
    endfunction

    // Control FSM. MAC j uses data read during the previous cycle, so a bin spends N+1 cycles in COMPUTE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            samp_cnt_reg  <= '0;
            bin_reg       <= '0;
            j_reg         <= '0;
            tw_idx_reg    <= '0;
            issue_reg     <= 1'b0;
            mac_valid_reg <= 1'b0;
            mac_last_reg  <= 1'b0;
            inv_reg       <= 1'b0;
            in_ready_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            out_re_reg    <= '0;
            out_im_reg    <= '0;
            out_idx_reg   <= '0;
            acc_re_reg    <= '0;
            acc_im_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    in_ready_reg <= 1'b1;
                    if (load_fire) begin
                        inv_reg      <= inverse;
                        samp_cnt_reg <= samp_cnt_reg + LW'(1);
                        state_reg    <= LOAD;
                    end
                end
                LOAD: begin
                    if (load_fire) begin
                        samp_cnt_reg <= samp_cnt_reg + LW'(1);
                        if (samp_cnt_reg == LAST) begin
                            state_reg    <= COMPUTE;
                            in_ready_reg <= 1'b0;
                            bin_reg      <= '0;
                            j_reg        <= '0;
                            tw_idx_reg   <= '0;
                            issue_reg    <= 1'b1;
                            acc_re_reg   <= '0;
                            acc_im_reg   <= '0;
                        end
                    end
                end
                COMPUTE: begin
                    if (issue_reg) begin
                        j_reg      <= j_reg + LW'(1);
                        tw_idx_reg <= tw_idx_reg + bin_reg;
                        if (j_reg == LAST)
                            issue_reg <= 1'b0;
                    end
                    mac_valid_reg <= issue_reg;
                    mac_last_reg  <= issue_reg && (j_reg == LAST);
                    if (mac_valid_reg) begin
                        acc_re_reg <= acc_re_next;
                        acc_im_reg <= acc_im_next;
                        if (mac_last_reg) begin
                            out_re_reg    <= round_reduce(acc_re_next);
                            out_im_reg    <= round_reduce(acc_im_next);
                            out_idx_reg   <= bin_reg;
                            out_valid_reg <= 1'b1;
                            state_reg     <= EMIT;
                        end
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        acc_re_reg    <= '0;
                        acc_im_reg    <= '0;
                        if (bin_reg == LAST) begin
                            state_reg    <= IDLE;
                            in_ready_reg <= 1'b1;
                            bin_reg      <= '0;
                        end else begin
                            state_reg  <= COMPUTE;
                            bin_reg    <= bin_reg + LW'(1);
                            j_reg      <= '0;
                            tw_idx_reg <= '0;
                            issue_reg  <= 1'b1;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_re    = out_re_reg;
    assign out_im    = out_im_reg;
    assign out_idx   = out_idx_reg;
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_dft_engine.sv
// Directed bench for dft_engine (N=16, W=16, TW=16): impulse, DC, backpressure,
// inverse round-trip, overflow and mid-frame reset, with hand-computed expectations.
module tb_dft_engine;
    localparam int N = 16;
    localparam int W = 16;

    logic                clk = 1'b0;
    logic                reset;
    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] in_re;
    logic signed [W-1:0] in_im;
    logic                inverse;
    logic                out_valid;
    logic                out_ready;
    logic signed [W-1:0] out_re;
    logic signed [W-1:0] out_im;
    logic [3:0]          out_idx;
    logic                busy;

    int errors = 0;
    int checks = 0;

    logic signed [W-1:0] src_re [N];
    logic signed [W-1:0] src_im [N];
    int                  res_re [N];
    int                  res_im [N];

    always #5 clk = ~clk;

    dft_engine #(.N(N), .W(W), .TW(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
        .inverse   (inverse),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_idx   (out_idx),
        .busy      (busy)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int absv(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic fill_src(input int re_val, input int im_val);
        for (int i = 0; i < N; i++) begin
            src_re[i] = 16'(re_val);
            src_im[i] = 16'(im_val);
        end
    endtask

    // inverse is driven only on sample 0 and inverted afterwards, so it must be captured there.
    task automatic send_frame(input logic inv);
        int waited;
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_re    = src_re[i];
            in_im    = src_im[i];
            inverse  = (i == 0) ? inv : ~inv;
            waited   = 0;
            while (!in_ready && waited < 50) begin
                @(negedge clk);
                waited++;
            end
            if (!in_ready) check("in_ready_timeout", 0, 1);
            @(posedge clk);
        end
    endtask

    // Collects bins 0..stop_bin-1; stall_bin (if >= 0) holds out_ready low for 20 cycles once valid.
    task automatic recv_frame(input int stall_bin, input int stop_bin);
        int         lat;
        logic [36:0] held;
        #1 in_valid = 1'b0;
        for (int b = 0; b < stop_bin; b++) begin
            out_ready = (b != stall_bin);
            lat = 0;
            do begin
                @(posedge clk);
                #1;
                lat++;
            end while (!out_valid && lat < 200);
            check("bin_latency", lat, N + 1);
            check("bin_idx", out_idx, b);
            if (b == 0) check("in_ready_busy", in_ready, 0);
            res_re[b] = int'(out_re);
            res_im[b] = int'(out_im);
            if (b == stall_bin) begin
                held = {out_valid, out_idx, out_re, out_im};
                for (int s = 0; s < 20; s++) begin
                    @(posedge clk);
                    #1;
                    check("stall_hold", {out_valid, out_idx, out_re, out_im}, held);
                end
                out_ready = 1'b1;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_impulse_1000();
        for (int b = 0; b < N; b++) begin
            check("impulse_re", res_re[b], 1000);
            check("impulse_im", res_im[b], 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_re     = '0;
        in_im     = '0;
        inverse   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_re", out_re, 0);
        check("rst_out_im", out_im, 0);
        check("rst_out_idx", out_idx, 0);
        reset = 1'b0;

        // Impulse x[0]=1000: every bin is 1000*32767/32768 rounded = 1000 + 0j.
        fill_src(0, 0);
        src_re[0] = 16'sd1000;
        send_frame(1'b0);
        recv_frame(-1, N);
        check_impulse_1000();
        $display("impulse frame done: bin0=(%0d,%0d) bin15=(%0d,%0d)", res_re[0], res_im[0], res_re[15], res_im[15]);

        // DC 100 with backpressure on bin 5: bin0 = 1600, the rest within 1 LSB of zero.
        fill_src(100, 0);
        send_frame(1'b0);
        recv_frame(5, N);
        check("dc_bin0_re", res_re[0], 1600);
        check("dc_bin0_im", res_im[0], 0);
        for (int b = 1; b < N; b++) begin
            check("dc_small_re", absv(res_re[b]) <= 1, 1);
            check("dc_small_im", absv(res_im[b]) <= 1, 1);
        end
        $display("dc frame done: bin0=(%0d,%0d) bin5=(%0d,%0d)", res_re[0], res_im[0], res_re[5], res_im[5]);

        // Impulse x[3]=500: X[k]=500*exp(-j*2*pi*3k/16). bin2 -> (-354,-354), bin4 -> (0,+500).
        fill_src(0, 0);
        src_re[3] = 16'sd500;
        send_frame(1'b0);
        recv_frame(-1, N);
        check("fwd3_bin0_re", res_re[0], 500);
        check("fwd3_bin0_im", res_im[0], 0);
        check("fwd3_bin2_re", res_re[2], -354);
        check("fwd3_bin2_im", res_im[2], -354);
        check("fwd3_bin4_re", res_re[4], 0);
        check("fwd3_bin4_im", res_im[4], 500);
        for (int i = 0; i < N; i++) begin
            src_re[i] = 16'(res_re[i]);
            src_im[i] = 16'(res_im[i]);
        end
        send_frame(1'b1);
        recv_frame(-1, N);
        check("inv_bin3_re", absv(res_re[3] - 8000) <= N, 1);
        check("inv_bin3_im", absv(res_im[3]) <= N, 1);
        for (int b = 0; b < N; b++) begin
            if (b != 3) begin
                check("inv_other_re", absv(res_re[b]) <= N, 1);
                check("inv_other_im", absv(res_im[b]) <= N, 1);
            end
        end
        $display("inverse frame done: bin3=(%0d,%0d)", res_re[3], res_im[3]);

        // All 32767: bin0 rounds to 524256 = 0x7FFE0, which wraps to -32 or saturates to 32767.
        fill_src(32767, 0);
        send_frame(1'b0);
        recv_frame(-1, N);
`ifdef DFT_SAT_EN
        check("ovf_bin0_re", res_re[0], 32767);
`else
        check("ovf_bin0_re", res_re[0], -32);
`endif
        check("ovf_bin0_im", res_im[0], 0);
        $display("overflow frame done: bin0=(%0d,%0d)", res_re[0], res_im[0]);

        // Abandon a frame while bin 7 is computing, then a fresh impulse frame must be intact.
        fill_src(0, 0);
        src_re[0] = 16'sd1000;
        send_frame(1'b0);
        recv_frame(-1, 7);
        repeat (5) @(posedge clk);
        #1;
        check("mid_busy", busy, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_out_idx", out_idx, 0);
        check("midrst_out_re", out_re, 0);
        reset = 1'b0;
        send_frame(1'b0);
        recv_frame(-1, N);
        check_impulse_1000();
        $display("post-reset frame done: bin0=(%0d,%0d)", res_re[0], res_im[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
